// File: rtl/frame_pkg.sv
// Shared register map and bit positions for the frame tick block.
package frame_pkg;

  localparam logic [1:0] STATUS_A = 2'd0;
  localparam logic [1:0] COUNT_A  = 2'd1;
  localparam logic [1:0] CTRL_A   = 2'd2;
  localparam logic [1:0] MISSED_A = 2'd3;

  localparam int PEND_BIT     = 0;
  localparam int OVR_BIT      = 1;
  localparam int LEVEL_BIT    = 2;
  localparam int IRQ_EN_BIT   = 0;
  localparam int COUNT_EN_BIT = 1;

  localparam logic [1:0]  CTRL_RESET = 2'b10;
  localparam logic [15:0] MISSED_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_debounce.sv
// Synchronizes raw vsync into clk, filters short glitches and flags the
// selected edge of the filtered level as a one-cycle tick.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit EDGE_FALLING    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync_in,
  output logic frame_level,
  output logic frame_tick
);

  localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             db_cnt;
  logic                   sync_in;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Multi-flop synchronizer; vsync_in enters at bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], vsync_in};
  end

  // Level flips only after the synced input has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; the tick is issued with the flip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt      <= '0;
      frame_level <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (sync_in != frame_level) begin
        if (db_cnt == CNT_TC) begin
          db_cnt      <= '0;
          frame_level <= ~frame_level;
          frame_tick  <= EDGE_FALLING ? frame_level : ~frame_level;
        end else begin
          db_cnt <= db_cnt + 8'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/frame_tick_sync.sv
// Frame tick conditioner with an Avalon-MM register file: sticky pending /
// overrun flags, frame and missed-frame counters, and a level interrupt.
module frame_tick_sync
  import frame_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit EDGE_FALLING    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        frame_tick,
  output logic        frame_level
);

  logic        pend_q;
  logic        ovr_q;
  logic [31:0] frame_count_q;
  logic [1:0]  ctrl_q;
  logic [15:0] missed_q;
  logic        wr_en;
  logic        unused_wdata;

  assign wr_en        = chipselect & write;
  assign unused_wdata = &{1'b0, writedata[31:2]};

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .EDGE_FALLING    (EDGE_FALLING)
  ) u_sync_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_in    (vsync_in),
    .frame_level (frame_level),
    .frame_tick  (frame_tick)
  );

  // Sticky flags: a tick always beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (frame_tick)
        pend_q <= 1'b1;
      else if (wr_en && address == STATUS_A && writedata[PEND_BIT])
        pend_q <= 1'b0;

      if (frame_tick && pend_q)
        ovr_q <= 1'b1;
      else if (wr_en && address == STATUS_A && writedata[OVR_BIT])
        ovr_q <= 1'b0;
    end
  end

  // Counters: a write clears and wins over a same-cycle tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      missed_q      <= '0;
    end else begin
      if (wr_en && address == COUNT_A)
        frame_count_q <= '0;
      else if (frame_tick && ctrl_q[COUNT_EN_BIT])
        frame_count_q <= frame_count_q + 32'd1;

      if (wr_en && address == MISSED_A)
        missed_q <= '0;
      else if (frame_tick && pend_q && missed_q != MISSED_MAX)
        missed_q <= missed_q + 16'd1;
    end
  end

  // Control register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         ctrl_q <= CTRL_RESET;
    else if (wr_en && address == CTRL_A)  ctrl_q <= writedata[1:0];
  end

  // Read data is registered from address every cycle, chipselect ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        STATUS_A: readdata <= {29'd0, frame_level, ovr_q, pend_q};
        COUNT_A:  readdata <= frame_count_q;
        CTRL_A:   readdata <= {30'd0, ctrl_q};
        MISSED_A: readdata <= {16'd0, missed_q};
        default:  readdata <= '0;
      endcase
    end
  end

  // Interrupt follows the pending flag one cycle later when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= pend_q & ctrl_q[IRQ_EN_BIT];
  end

endmodule
